seg_scan_ctrl: RTL and testbench

- Parametrised N-digit multiplexed 7-segment driver; successor to the fixed 4-digit scanner. Scan rate, digit count and numeric field width are parameters.
- Content arrives through a load/busy handshake: per-digit glyph codes plus an optional binary number. The number is converted to decimal by a sequential double-dabble and shown with leading-zero blanking.
- Sits between the calculator control FSM (mode letters, countdown, matrix id) and the board's common-cathode digits.

---
 rtl/seg_scan_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl - N-digit multiplexed common-cathode 7-segment driver.
//
// The scan runs continuously from a shadow frame (glyph code + dp per digit).
// New content is staged through a load/busy handshake. An optional binary
// number is converted to BCD by a sequential double-dabble and written into
// the low NUM_FIELD digits, with leading-zero blanking and an overflow dash.
//
// Compile-time option: define SEG_BLINK_EN to add a 2 Hz blink phase gated
// per digit by blink_mask. Without it, blink_mask is ignored.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : one-cycle content request (ignored while busy)
//   busy        : high while a load is being processed
//   code_in     : 5-bit glyph code per digit, digit 0 in bits [4:0]
//   dp_in       : decimal point per digit
//   num_en      : numeric field overrides code_in on digits 0..NUM_FIELD-1
//   num_in      : unsigned binary value for the numeric field
//   blink_mask  : per-digit blink enable (SEG_BLINK_EN only)
//   seg_sel     : one-hot digit select, active high
//   seg_data    : segments {dp,g,f,e,d,c,b,a}, active high
//
// The FSM state is held in state_q (ctrl_state_e) for checker binding.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int VAL_W        = 8,
  parameter int NUM_FIELD    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  output logic                    busy,
  input  logic [5*NUM_DIGITS-1:0] code_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    num_en,
  input  logic [VAL_W-1:0]        num_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic [7:0]              seg_data
);

  // Decimal digits needed to hold the largest VAL_W-bit value.
  function automatic int dec_digits(input int bits);
    longint unsigned v;
    int d;
    v = (64'd1 << bits) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

  localparam int DWELL  = CLK_FREQ / (SCAN_HZ * NUM_DIGITS);
  localparam int CNT_W  = $clog2(DWELL);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SHC_W  = $clog2(VAL_W + 1);
  localparam int BCD_N  = dec_digits(VAL_W);
  // Wide enough for both the conversion and the field, so overflow is simply
  // "a nonzero digit above the field".
  localparam int BCD_D  = (BCD_N > NUM_FIELD) ? BCD_N : NUM_FIELD;

  localparam logic [4:0] CODE_BLANK = 5'd31;
  localparam logic [4:0] CODE_DASH  = 5'd23;

  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'd0:    glyph = 7'h3F;
      5'd1:    glyph = 7'h06;
      5'd2:    glyph = 7'h5B;
      5'd3:    glyph = 7'h4F;
      5'd4:    glyph = 7'h66;
      5'd5:    glyph = 7'h6D;
      5'd6:    glyph = 7'h7D;
      5'd7:    glyph = 7'h07;
      5'd8:    glyph = 7'h7F;
      5'd9:    glyph = 7'h6F;
      5'd16:   glyph = 7'h06;  // I
      5'd17:   glyph = 7'h3D;  // G
      5'd18:   glyph = 7'h78;  // T
      5'd19:   glyph = 7'h77;  // A
      5'd20:   glyph = 7'h7C;  // b
      5'd21:   glyph = 7'h39;  // C
      5'd22:   glyph = 7'h1E;  // J
      5'd23:   glyph = 7'h40;  // -
      default: glyph = 7'h00;
    endcase
  endfunction

  // Handshake: a load is accepted on any clock edge where load=1 and busy=0;
  // busy rises on that edge and stays high until the shadow frame has been
  // replaced in one step. Loads seen while busy=1 are dropped.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COPY,
    ST_CONV,
    ST_FMT
  } ctrl_state_e;

  ctrl_state_e state_q, state_d;

  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_DIGITS-1:0]           sel_q, sel_d;
  logic [7:0]                      data_q, data_d;

  logic [NUM_DIGITS-1:0][4:0]      stg_code_q, stg_code_d;
  logic [NUM_DIGITS-1:0]           stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0][4:0]      sh_code_q, sh_code_d;
  logic [NUM_DIGITS-1:0]           sh_dp_q, sh_dp_d;

  logic [VAL_W-1:0]                bin_q, bin_d;
  logic [4*BCD_D-1:0]              bcd_q, bcd_d;
  logic [SHC_W-1:0]                shc_q, shc_d;

  logic [4*BCD_D-1:0]              adj;
  logic [NUM_DIGITS-1:0][4:0]      fld_code;
  logic                            ovf;
  logic                            seen;
  logic                            blink_hide;

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_D; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Field formatting from the finished BCD value. Scanning from the top
  // digit down, a digit shows once any nonzero digit has been seen; digit 0
  // always shows so zero reads as "0".
  always_comb begin
    ovf      = 1'b0;
    seen     = 1'b0;
    fld_code = stg_code_q;
    for (int i = NUM_FIELD; i < BCD_D; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) ovf = 1'b1;
    end
    for (int i = NUM_FIELD - 1; i >= 0; i--) begin
      if ((bcd_q[4*i +: 4] != 4'd0) || (i == 0)) seen = 1'b1;
      if (ovf)       fld_code[i] = CODE_DASH;
      else if (seen) fld_code[i] = {1'b0, bcd_q[4*i +: 4]};
      else           fld_code[i] = CODE_BLANK;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK_HALF = CLK_FREQ / 4;
  localparam int BLC_W      = $clog2(BLINK_HALF + 1);

  logic [BLC_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_off_q, blink_off_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_off_d = blink_off_q;
    if (blink_cnt_q == BLC_W'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign blink_hide = blink_off_q & blink_mask[idx_q];
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blink_hide        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    sel_d      = '0;
    data_d     = '0;
    stg_code_d = stg_code_q;
    stg_dp_d   = stg_dp_q;
    sh_code_d  = sh_code_q;
    sh_dp_d    = sh_dp_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    shc_d      = shc_q;

    // Scan timing: never paused by loads.
    if (cnt_q == CNT_W'(DWELL - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // Registered outputs, leading blank window suppresses ghosting.
    if (cnt_q >= CNT_W'(BLANK_CYCLES)) begin
      sel_d[idx_q] = 1'b1;
      if (!blink_hide) data_d = {sh_dp_q[idx_q], glyph(sh_code_q[idx_q])};
    end

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          stg_code_d = code_in;
          stg_dp_d   = dp_in;
          bin_d      = num_in;
          bcd_d      = '0;
          shc_d      = '0;
          state_d    = num_en ? ST_CONV : ST_COPY;
        end
      end
      ST_COPY: begin
        sh_code_d = stg_code_q;
        sh_dp_d   = stg_dp_q;
        state_d   = ST_IDLE;
      end
      ST_CONV: begin
        bcd_d = {adj[4*BCD_D-2:0], bin_q[VAL_W-1]};
        bin_d = bin_q << 1;
        shc_d = shc_q + 1'b1;
        if (shc_q == SHC_W'(VAL_W - 1)) state_d = ST_FMT;
      end
      ST_FMT: begin
        sh_code_d = fld_code;
        sh_dp_d   = stg_dp_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      stg_code_q <= {NUM_DIGITS{CODE_BLANK}};
      stg_dp_q   <= '0;
      sh_code_q  <= {NUM_DIGITS{CODE_BLANK}};
      sh_dp_q    <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      shc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      stg_code_q <= stg_code_d;
      stg_dp_q   <= stg_dp_d;
      sh_code_q  <= sh_code_d;
      sh_dp_q    <= sh_dp_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      shc_q      <= shc_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign seg_sel  = sel_q;
  assign seg_data = data_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (numeric field of 3 and of 2
// digits) share all inputs. A reference model predicts, per clock, busy and
// the scan outputs of both instances from the display rules; a monitor
// compares on the falling edge.
module tb_seg_scan_ctrl;
  localparam int ND         = 4;
  localparam int CLK_FREQ   = 8000;
  localparam int SCAN_HZ    = 250;
  localparam int BLANK      = 2;
  localparam int VAL_W      = 8;
  localparam int DWELL      = CLK_FREQ / (SCAN_HZ * ND);
  localparam int BLINK_HALF = CLK_FREQ / 4;

  // ---------------- clock / reset / DUTs ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load = 1'b0;
  logic              num_en = 1'b0;
  logic [5*ND-1:0]   code_in = '0;
  logic [ND-1:0]     dp_in = '0;
  logic [ND-1:0]     blink_mask = '0;
  logic [VAL_W-1:0]  num_in = '0;
  logic              busy3, busy2;
  logic [ND-1:0]     sel3, sel2;
  logic [7:0]        data3, data2;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .CLK_FREQ(CLK_FREQ), .SCAN_HZ(SCAN_HZ),
                  .BLANK_CYCLES(BLANK), .VAL_W(VAL_W), .NUM_FIELD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .load(load), .busy(busy3), .code_in(code_in),
    .dp_in(dp_in), .num_en(num_en), .num_in(num_in), .blink_mask(blink_mask),
    .seg_sel(sel3), .seg_data(data3)
  );

  seg_scan_ctrl #(.NUM_DIGITS(ND), .CLK_FREQ(CLK_FREQ), .SCAN_HZ(SCAN_HZ),
                  .BLANK_CYCLES(BLANK), .VAL_W(VAL_W), .NUM_FIELD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load), .busy(busy2), .code_in(code_in),
    .dp_in(dp_in), .num_en(num_en), .num_in(num_in), .blink_mask(blink_mask),
    .seg_sel(sel2), .seg_data(data2)
  );

  // ---------------- scoreboard state ----------------
  logic [25:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] glyph_of(input int c);
    case (c)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  16: return 7'h06; 17: return 7'h3D;
      18: return 7'h78; 19: return 7'h77; 20: return 7'h7C; 21: return 7'h39;
      22: return 7'h1E; 23: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // Code shown on field digit d (d < f) for value num.
  function automatic int field_code(input int f, input int num, input int d);
    if (num >= pow10(f)) return 23;
    if (d > 0 && num < pow10(d)) return 31;
    return (num / pow10(d)) % 10;
  endfunction

  function automatic int field_of(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  int edge_n;
  int busy_left;
  int sh_code[2][ND];
  bit sh_dp[ND];
  int pend_code[2][ND];
  bit pend_dp[ND];
  int s_m, pos_m, dig_m;
  bit off_m;
  logic [ND-1:0] sel_m;
  logic [7:0] dat_m[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n    = 0;
      busy_left = 0;
      for (int d = 0; d < ND; d++) begin
        sh_dp[d] = 1'b0;
        for (int k = 0; k < 2; k++) sh_code[k][d] = 31;
      end
      exp_q.delete();
    end else begin
      edge_n++;
      // Outputs registered on this edge reflect the scan position of the
      // previous cycle and the frame held before this edge.
      s_m   = edge_n - 1;
      pos_m = s_m % DWELL;
      dig_m = (s_m / DWELL) % ND;
      off_m = 1'b0;
`ifdef SEG_BLINK_EN
      off_m = (((s_m / BLINK_HALF) % 2) == 1) && blink_mask[dig_m];
`endif
      sel_m = (pos_m < BLANK) ? '0 : ND'(1 << dig_m);
      for (int k = 0; k < 2; k++) begin
        if (pos_m < BLANK || off_m) dat_m[k] = 8'h00;
        else dat_m[k] = {sh_dp[dig_m], glyph_of(sh_code[k][dig_m])};
      end

      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          for (int d = 0; d < ND; d++) begin
            sh_dp[d] = pend_dp[d];
            for (int k = 0; k < 2; k++) sh_code[k][d] = pend_code[k][d];
          end
        end
      end else if (load) begin
        for (int d = 0; d < ND; d++) begin
          pend_dp[d] = dp_in[d];
          for (int k = 0; k < 2; k++) begin
            if (num_en && d < field_of(k))
              pend_code[k][d] = field_code(field_of(k), int'(num_in), d);
            else
              pend_code[k][d] = int'(code_in[5*d +: 5]);
          end
        end
        busy_left = num_en ? VAL_W + 1 : 1;
      end

      exp_q.push_back({(busy_left > 0), sel_m, dat_m[0], (busy_left > 0), sel_m, dat_m[1]});
    end
  end

  // ---------------- monitor ----------------
  logic [25:0] e_mon;
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      check("busy_f3", 16'(busy3), 16'(e_mon[25]));
      check("sel_f3",  16'(sel3),  16'(e_mon[24:21]));
      check("data_f3", 16'(data3), 16'(e_mon[20:13]));
      check("busy_f2", 16'(busy2), 16'(e_mon[12]));
      check("sel_f2",  16'(sel2),  16'(e_mon[11:8]));
      check("data_f2", 16'(data2), 16'(e_mon[7:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input logic [5*ND-1:0] codes, input logic [ND-1:0] dps,
                         input logic en, input logic [VAL_W-1:0] num);
    code_in = codes;
    dp_in   = dps;
    num_en  = en;
    num_in  = num;
    load    = 1'b1;
    tick(1);
    load    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy3"}, 16'(busy3), 16'h0);
    check({tag, "_sel3"},  16'(sel3),  16'h0);
    check({tag, "_data3"}, 16'(data3), 16'h0);
    check({tag, "_busy2"}, 16'(busy2), 16'h0);
    check({tag, "_sel2"},  16'(sel2),  16'h0);
    check({tag, "_data2"}, 16'(data2), 16'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    tick(3);
    #1;
    check_reset_outputs("reset");
    #1;
    rst_n = 1'b1;

    // Blank frame: scan walks the digits with nothing lit.
    tick(40);

    // Letter + digit, no numeric field.
    do_load({5'd19, 5'd31, 5'd31, 5'd2}, 4'b0000, 1'b0, 8'd0);
    tick(40);

    // Numeric 7, then a second load while busy that must be dropped.
    do_load({5'd18, 5'd4, 5'd4, 5'd4}, 4'b1000, 1'b1, 8'd7);
    tick(3);
    do_load({5'd21, 5'd21, 5'd21, 5'd21}, 4'b1111, 1'b0, 8'd0);
    tick(40);

    // Overflow for the 2-digit field, full 255 on the 3-digit field.
    do_load({5'd23, 5'd17, 5'd0, 5'd0}, 4'b0101, 1'b1, 8'd255);
    tick(40);

    // Value zero shows a single "0".
    do_load({5'd20, 5'd9, 5'd9, 5'd9}, 4'b0000, 1'b1, 8'd0);
    tick(40);

    // Reset in the middle of a conversion.
    do_load({5'd1, 5'd2, 5'd3, 5'd4}, 4'b0010, 1'b1, 8'd200);
    tick(4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(40);

    // Random traffic, including loads that land while busy.
    for (int i = 0; i < 600; i++) begin
      code_in = (5*ND)'($urandom);
      dp_in   = ND'($urandom);
      num_en  = ($urandom_range(0, 1) == 1);
      num_in  = VAL_W'($urandom_range(0, 255));
      load    = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    load = 1'b0;
    tick(20);

    // Blink on digit 0 only (steady when the blink option is compiled out).
    blink_mask = 4'b0001;
    do_load({5'd3, 5'd2, 5'd1, 5'd8}, 4'b0001, 1'b0, 8'd0);
    tick(4200);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
